alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised execute-stage ALU, successor of the combinational 16-bit ALU. Adds a registered
//  result, a condition-code register (CCR) and a multi-cycle barrel-free shifter (1 bit/cycle).
//  Uses a valid/ready handshake to the decode stage. Accepts flush and CCR restore (RTI) from control.
// PARAMETERS
//  WIDTH  16               datapath width; power of 2, >= 4
//  SHW    $clog2(WIDTH)    shift-amount width (derived; do not override)
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      op/operands valid
//  in_ready     out  1      unit can accept; = (state==IDLE)
//  op           in   4      opcode (table below)
//  in1          in   WIDTH  operand A
//  in2          in   WIDTH  operand B
//  shamt        in   SHW    shift amount for SHL/SHR
//  flush        in   1      abort in-flight op, block acceptance this cycle
//  flag_restore in   1      load CCR from flag_in
//  flag_in      in   3      CCR restore value
//  out          out  WIDTH  registered result
//  out_valid    out  1      one-cycle pulse: out/flag updated for completed op
//  flag         out  3      CCR: [0]=Z, [1]=C, [2]=N
// BEHAVIOUR
//  Reset: state=IDLE, out=0, flag=3'b000, out_valid=0, in_ready=1.
//  Async reset mid-shift: the op is dropped and no out_valid is produced.
//  Accept at edge E0 when in_valid & in_ready & ~flush.
//  Opcodes: 0 NOP; 1 LDD, 2 STD, 7 LDM: out=in1; 3 ADD in1+in2; 4 NOT ~in2; 5 SUB in1-in2;
//   6 AND; 8 OR; 9 INC in2+1; A DEC in2-1; B SHL in1<<shamt; C SHR in1>>shamt (logical);
//   D SETC; E CLRC; F reserved = NOP.
//  Single-cycle ops (all except SHL/SHR with shamt!=0): out/flag written at E0, out_valid=1 in the
//   following cycle, in_ready stays 1 (back-to-back issue every cycle).
//  NOP, SETC, CLRC: out unchanged, out_valid still pulses.
//  Shift FSM IDLE->SHIFT: at E0 load acc=in1, cnt=shamt. Each edge in SHIFT shifts acc 1 bit and
//   decrements cnt. At the edge where cnt goes 1->0: write out, flags, out_valid=1, return to IDLE.
//   out_valid is high in the cycle after E0+shamt; in_ready=0 for exactly shamt cycles.
//   In the out_valid cycle in_ready=1.
//  shamt==0: single-cycle pass of in1; Z,N updated; C unchanged.
//  Flags, arithmetic on WIDTH+1 bits:
//   Z = (out==0), N = out[WIDTH-1], updated for ADD,SUB,NOT,AND,OR,INC,DEC,SHL,SHR.
//   C = carry-out for ADD/INC; borrow (in1<in2 unsigned, or in2==0 for DEC) for SUB/DEC;
//    last bit shifted out for SHL/SHR; 1 for SETC; 0 for CLRC.
//   C unchanged for NOT/AND/OR. Pass ops/NOP leave all flags unchanged.
//  flag_restore: flag<=flag_in at that edge; overrides any same-edge flag update from a completing op
//   (out still written, out_valid still pulses).
//  flush: in SHIFT, forces IDLE at the edge; no out_valid; out/flag unchanged.
//   With in_valid in IDLE, the op is not accepted. flush and flag_restore together: both take effect.
// TESTING
//  1 Reset: rst_n=0 mid-SHL shamt=5 -> out=0, flag=0, out_valid never pulses, in_ready=1 after release.
//  2 ADD 0xFFFF+0x0001 -> next cycle out=0x0000, out_valid=1, flag Z=1 C=1 N=0; then SUB 3-5 -> 0xFFFE, Z=0 C=1 N=1.
//  3 SHL in1=0x8001 shamt=3 -> in_ready=0 for 3 cycles, then out=0x0008, C=0; SHR 0x0005 shamt=1 -> 0x0002, C=1.
//  4 SHR shamt=6, flush on 3rd busy cycle -> no out_valid, out/flag unchanged, in_ready=1 next cycle.
//  5 ADD 0x7FFF+1 with flag_restore=1, flag_in=3'b010 same edge -> out=0x8000, flag=3'b010.
//  6 Back-to-back: ADD, NOT 0x00FF, SETC, LDD 0x1234 on 4 consecutive cycles -> 4 out_valid pulses,
//    outs 0x.., 0xFF00, unchanged, 0x1234; C=1 after SETC and preserved by LDD.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with condition codes; single-cycle ops issue back-to-back, out_valid one cycle after accept.
// Non-zero shifts run 1 bit/cycle and hold in_ready low for shamt cycles; flush aborts, flag_restore loads the CCR.
module alu_exec_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [SHW-1:0]   shamt,
  input  logic             flush,
  input  logic             flag_restore,
  input  logic [2:0]       flag_in,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [2:0]       flag
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDD = 4'h1, OP_STD = 4'h2, OP_ADD  = 4'h3,
    OP_NOT  = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_LDM  = 4'h7,
    OP_OR   = 4'h8, OP_INC = 4'h9, OP_DEC = 4'hA, OP_SHL  = 4'hB,
    OP_SHR  = 4'hC, OP_SETC = 4'hD, OP_CLRC = 4'hE, OP_RSVD = 4'hF
  } op_t;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};

  state_t           state, state_n;
  op_t              op_c;
  logic [WIDTH-1:0] acc, acc_n, acc_sh, out_n;
  logic [SHW-1:0]   cnt, cnt_n;
  logic             dir_left, dir_left_n, shift_c;
  logic [2:0]       flag_n;
  logic             out_valid_n;
  logic             accept;
  logic [WIDTH:0]   add_w, sub_w, inc_w, dec_w;

  // CCR layout {N, C, Z}
  function automatic logic [2:0] ncz(input logic [WIDTH-1:0] v, input logic c);
    return {v[WIDTH-1], c, (v == '0)};
  endfunction

  assign op_c     = op_t'(op);
  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready & ~flush;

  // Top bit of each WIDTH+1 result is carry-out or borrow
  assign add_w = {1'b0, in1} + {1'b0, in2};
  assign sub_w = {1'b0, in1} - {1'b0, in2};
  assign inc_w = {1'b0, in2} + ONE_W;
  assign dec_w = {1'b0, in2} - ONE_W;

  assign acc_sh  = dir_left ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};
  assign shift_c = dir_left ? acc[WIDTH-1] : acc[0];

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    dir_left_n  = dir_left;
    out_n       = out;
    flag_n      = flag;
    out_valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          out_valid_n = 1'b1;
          case (op_c)
            OP_LDD, OP_STD, OP_LDM: out_n = in1;
            OP_ADD: begin out_n = add_w[WIDTH-1:0]; flag_n = ncz(add_w[WIDTH-1:0], add_w[WIDTH]); end
            OP_SUB: begin out_n = sub_w[WIDTH-1:0]; flag_n = ncz(sub_w[WIDTH-1:0], sub_w[WIDTH]); end
            OP_INC: begin out_n = inc_w[WIDTH-1:0]; flag_n = ncz(inc_w[WIDTH-1:0], inc_w[WIDTH]); end
            OP_DEC: begin out_n = dec_w[WIDTH-1:0]; flag_n = ncz(dec_w[WIDTH-1:0], dec_w[WIDTH]); end
            OP_NOT: begin out_n = ~in2;       flag_n = ncz(~in2, flag[1]); end
            OP_AND: begin out_n = in1 & in2;  flag_n = ncz(in1 & in2, flag[1]); end
            OP_OR:  begin out_n = in1 | in2;  flag_n = ncz(in1 | in2, flag[1]); end
            OP_SHL, OP_SHR: begin
              if (shamt == '0) begin
                out_n  = in1;
                flag_n = ncz(in1, flag[1]);
              end else begin
                out_valid_n = 1'b0;
                state_n     = SHIFT;
                acc_n       = in1;
                cnt_n       = shamt;
                dir_left_n  = (op_c == OP_SHL);
              end
            end
            OP_SETC: flag_n[1] = 1'b1;
            OP_CLRC: flag_n[1] = 1'b0;
            default: ;
          endcase
        end
      end
      SHIFT: begin
        if (flush) begin
          state_n = IDLE;
        end else begin
          acc_n = acc_sh;
          cnt_n = cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            out_n       = acc_sh;
            flag_n      = ncz(acc_sh, shift_c);
            out_valid_n = 1'b1;
            state_n     = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Restore from control wins over any same-edge update
    if (flag_restore) flag_n = flag_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      dir_left  <= 1'b0;
      out       <= '0;
      flag      <= 3'b000;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      dir_left  <= dir_left_n;
      out       <= out_n;
      flag      <= flag_n;
      out_valid <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, flag layout {N,C,Z}.
module tb_alu_exec_unit;

  localparam int W  = 16;
  localparam int SW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op = 4'h0;
  logic [W-1:0]  in1 = '0;
  logic [W-1:0]  in2 = '0;
  logic [SW-1:0] shamt = '0;
  logic          flush = 1'b0;
  logic          flag_restore = 1'b0;
  logic [2:0]    flag_in = 3'b000;
  logic [W-1:0]  out;
  logic          out_valid;
  logic [2:0]    flag;

  int n_chk  = 0;
  int n_fail = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .in1(in1), .in2(in2), .shamt(shamt), .flush(flush),
    .flag_restore(flag_restore), .flag_in(flag_in),
    .out(out), .out_valid(out_valid), .flag(flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SW-1:0] s);
    in_valid = 1'b1;
    op = o; in1 = a; in2 = b; shamt = s;
    tick();
    in_valid = 1'b0;
  endtask

  // Count cycles with in_ready low; bounded so a stuck unit still reaches the summary
  task automatic wait_ready(input string tag, input int exp_busy);
    int busy;
    busy = 0;
    for (int i = 0; i < 40 && !in_ready; i++) begin
      busy++;
      tick();
    end
    check(tag, 32'(busy), 32'(exp_busy));
  endtask

  task automatic count_pulses(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check(tag, 32'(pulses), 0);
  endtask

  task automatic expect_result(input string tag, input logic [W-1:0] e_out, input logic [2:0] e_flag);
    check({tag, "_vld"},  32'(out_valid), 1);
    check({tag, "_out"},  32'(out), 32'(e_out));
    check({tag, "_flag"}, 32'(flag), 32'(e_flag));
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_out", 32'(out), 0);
    check("rst_flag", 32'(flag), 0);
    check("rst_vld", 32'(out_valid), 0);
    check("rst_rdy", 32'(in_ready), 1);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a shift
    issue(4'h3, 16'h0001, 16'h0002, '0);
    expect_result("pre_add", 16'h0003, 3'b000);
    issue(4'hB, 16'h0003, 16'h0000, 4'd5);
    check("shl5_busy", 32'(in_ready), 0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(out), 0);
    check("midrst_flag", 32'(flag), 0);
    check("midrst_rdy", 32'(in_ready), 1);
    tick();
    rst_n = 1'b1;
    count_pulses("midrst_nopulse", 8);
    check("postrst_rdy", 32'(in_ready), 1);

    // ADD with carry to zero, then SUB with borrow
    issue(4'h3, 16'hFFFF, 16'h0001, '0);
    expect_result("add_wrap", 16'h0000, 3'b011);
    issue(4'h5, 16'h0003, 16'h0005, '0);
    expect_result("sub_borrow", 16'hFFFE, 3'b110);
    tick();
    check("vld_single_pulse", 32'(out_valid), 0);

    // Multi-cycle shifts
    issue(4'hB, 16'h8001, 16'h0000, 4'd3);
    wait_ready("shl3_busy", 3);
    expect_result("shl3", 16'h0008, 3'b000);
    issue(4'hC, 16'h0005, 16'h0000, 4'd1);
    wait_ready("shr1_busy", 1);
    expect_result("shr1", 16'h0002, 3'b010);

    // Flush on the third busy cycle of a 6-cycle shift
    issue(4'hC, 16'hF000, 16'h0000, 4'd6);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_rdy", 32'(in_ready), 1);
    check("flush_vld", 32'(out_valid), 0);
    check("flush_out", 32'(out), 32'h0002);
    check("flush_flag", 32'(flag), 32'(3'b010));
    count_pulses("flush_nopulse", 8);

    // Flush in IDLE blocks acceptance; restore in the same cycle still lands
    flush = 1'b1; flag_restore = 1'b1; flag_in = 3'b101;
    issue(4'h3, 16'h0001, 16'h0001, '0);
    flush = 1'b0; flag_restore = 1'b0;
    check("idleflush_vld", 32'(out_valid), 0);
    check("idleflush_out", 32'(out), 32'h0002);
    check("idleflush_flag", 32'(flag), 32'(3'b101));

    // Restore overrides the completing op's flags
    flag_restore = 1'b1; flag_in = 3'b010;
    issue(4'h3, 16'h7FFF, 16'h0001, '0);
    flag_restore = 1'b0;
    expect_result("add_restore", 16'h8000, 3'b010);

    // Back-to-back single-cycle issue
    issue(4'h3, 16'h0001, 16'h0002, '0);
    expect_result("b2b_add", 16'h0003, 3'b000);
    check("b2b_rdy", 32'(in_ready), 1);
    issue(4'h4, 16'h0000, 16'h00FF, '0);
    expect_result("b2b_not", 16'hFF00, 3'b100);
    issue(4'hD, 16'h0000, 16'h0000, '0);
    expect_result("b2b_setc", 16'hFF00, 3'b110);
    issue(4'h1, 16'h1234, 16'h0000, '0);
    expect_result("b2b_ldd", 16'h1234, 3'b110);

    // Remaining opcodes and shamt==0
    issue(4'h9, 16'h0000, 16'hFFFF, '0);
    expect_result("inc_wrap", 16'h0000, 3'b011);
    issue(4'hA, 16'h0000, 16'h0000, '0);
    expect_result("dec_zero", 16'hFFFF, 3'b110);
    issue(4'h6, 16'hF0F0, 16'h0FF0, '0);
    expect_result("and", 16'h00F0, 3'b010);
    issue(4'hE, 16'h0000, 16'h0000, '0);
    expect_result("clrc", 16'h00F0, 3'b000);
    issue(4'h8, 16'h8000, 16'h0001, '0);
    expect_result("or", 16'h8001, 3'b100);
    issue(4'hD, 16'h0000, 16'h0000, '0);
    issue(4'hB, 16'h0000, 16'h0000, '0);
    expect_result("shl0", 16'h0000, 3'b011);
    check("shl0_rdy", 32'(in_ready), 1);
    issue(4'h0, 16'h5555, 16'h5555, '0);
    expect_result("nop", 16'h0000, 3'b011);
    issue(4'hF, 16'h5555, 16'h5555, '0);
    expect_result("rsvd", 16'h0000, 3'b011);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
